arm_hazard_sb: RTL
==================

# arm_hazard_sb

Parametrised scoreboard hazard unit for the pipelined ARM core, the successor to the combinational `hazard` block. It keeps its own E/M/W copies of destination tags and control bits, so the datapath no longer computes Match_* signals. It generates forwarding selects, load-use stalls, branch and PC-write flushes, and a configurable multi-cycle data-memory stall that freezes the whole pipeline.

## Interface
Parameters:
- REGBITS, 4, register-specifier width (2**REGBITS architectural registers)
- PCREG, 15, register index treated as the PC (never forwarded)
- MEMLAT, 0, extra M-stage cycles per memory access (0..7); 0 gives single-cycle memory

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- RA1D, RA2D  in  REGBITS  D-stage source registers
- Use1D, Use2D  in  1  D instruction actually reads RA1D / RA2D
- WA3D  in  REGBITS  D-stage destination register
- RegWriteD, MemtoRegD, MemAccD, PCSrcD  in  1  D-stage controls; MemAccD = load or store
- CondExE  in  1  condition check passed for the E instruction
- BranchTakenE  in  1  branch resolved taken in E
- StallF, StallD, StallE, StallM, StallW  out  1  hold the corresponding pipeline register
- FlushD, FlushE  out  1  load a bubble into the D / E register
- ForwardAE, ForwardBE  out  2  00 regfile, 01 from W result, 10 from ALUOutM
- PCWrPendingF  out  1  PC write in flight in D, E or M
- MemBusyM  out  1  memory stall counter non-zero

## Operation
- Internal tag registers per stage X in {E,M,W}: RA1X, RA2X (E only), WA3X, RegWriteX, MemtoRegX, MemAccX, PCSrcX.
- D→E: loads on !StallE. If FlushE, it loads a bubble (all control bits 0).
- E→M: loads on !StallM. Control bits are ANDed with CondExE.
- M→W: loads on !StallW.
- Forwarding for RA1E (RA2E identical):
  - 10 if RegWriteM && WA3M==RA1E && RA1E!=PCREG.
  - Otherwise 01 if RegWriteW && WA3W==RA1E && RA1E!=PCREG.
  - Otherwise 00.
  - M has priority over W.
- ldrStall = MemtoRegE && ((Use1D && RA1D==WA3E) || (Use2D && RA2D==WA3E)).
- PCWrPendingF = PCSrcD | PCSrcE | PCSrcM.
- Memory stall counter cnt (3 bits):
  - Loads MEMLAT when an instruction with MemAccE && CondExE advances E→M.
  - Otherwise decrements while non-zero.
- memStall = (cnt != 0), and MemBusyM = memStall.
- When memStall=1:
  - StallF, StallD, StallE, StallM and StallW are all 1.
  - FlushD and FlushE are 0 (branch and load-use effects wait; E contents are held, so they re-evaluate).
  - W is held, so its regfile write repeats harmlessly and its forwarding remains valid.
- When memStall=0:
  - StallF = ldrStall | PCWrPendingF
  - StallD = ldrStall
  - StallE = StallM = StallW = 0
  - FlushD = PCWrPendingF | PCSrcW | BranchTakenE
  - FlushE = ldrStall | BranchTakenE
- Back-to-back memory accesses: the second access reloads cnt in the cycle the first leaves M, so each access gets MEMLAT stall cycles.

## Timing
- All outputs are combinational from the inputs and the internal tag registers. There is no output register.
- Reset clears every tag register and cnt. With D inputs at 0, every output is 0 in the cycle after reset.
- Reset asserted mid-stall: cnt=0 and all tags cleared at that edge. The stall ends immediately.
- Load-use penalty is 1 cycle. Taken-branch penalty is 2 bubbles (D and E).
- A PC-writing instruction holds F while it is in D/E/M and flushes D through W.
- A memory access holds the pipeline for exactly MEMLAT cycles after entering M. With MEMLAT=0, memStall is never asserted.
- Simultaneous events:
  - memStall dominates everything.
  - BranchTakenE together with ldrStall: FlushE=1, FlushD=1, StallD=1. The bubble wins; the datapath applies flush over stall.
  - A CondExE=0 instruction never writes tags, never stalls memory and never forwards.

## Test plan
- Forward priority: ADD r1 in M and SUB r1 in W, E reads r1 as RA1 → ForwardAE=10. After M retires (W=ADD only) → 01. RA1E=15 with WA3M=15 → 00.
- Load-use: LDR r2 in E (MemtoRegE=1), D has Use2D=1, RA2D=2 → StallF=StallD=FlushE=1 for one cycle, then 0.
- Branch: BranchTakenE=1 → FlushD=FlushE=1 that cycle only. PCSrcD=1 → PCWrPendingF=1 for 3 cycles, then FlushD via PCSrcW on the 4th.
- MEMLAT=2: STR with CondExE=1 enters M → MemBusyM and all Stall* = 1 for exactly 2 cycles, FlushD=FlushE=0. BranchTakenE asserted during the stall flushes only after the stall. With CondExE=0 → no stall.
- Back-to-back LDR, LDR with MEMLAT=2 → 4 stall cycles total, forwarding from W held during the stall.
- Reset at the 2nd stall cycle → the next cycle has MemBusyM=0, all Stall*/Flush*=0, and ForwardAE=ForwardBE=00.

Source files
------------

// File: rtl/arm_hazard_sb_if.sv
// Signal bundle between the pipelined ARM datapath and the scoreboard hazard unit.
// The datapath (master) presents D-stage tags and E-stage resolution; the unit (slave) returns stall/flush/forward controls.
interface arm_hazard_sb_if #(
    parameter int REGBITS = 4
);
    logic [REGBITS-1:0] RA1D;
    logic [REGBITS-1:0] RA2D;
    logic               Use1D;
    logic               Use2D;
    logic [REGBITS-1:0] WA3D;
    logic               RegWriteD;
    logic               MemtoRegD;
    logic               MemAccD;
    logic               PCSrcD;
    logic               CondExE;
    logic               BranchTakenE;

    logic               StallF;
    logic               StallD;
    logic               StallE;
    logic               StallM;
    logic               StallW;
    logic               FlushD;
    logic               FlushE;
    logic [1:0]         ForwardAE;
    logic [1:0]         ForwardBE;
    logic               PCWrPendingF;
    logic               MemBusyM;

    modport master (
        output RA1D, RA2D, Use1D, Use2D, WA3D,
        output RegWriteD, MemtoRegD, MemAccD, PCSrcD,
        output CondExE, BranchTakenE,
        input  StallF, StallD, StallE, StallM, StallW,
        input  FlushD, FlushE, ForwardAE, ForwardBE,
        input  PCWrPendingF, MemBusyM
    );

    modport slave (
        input  RA1D, RA2D, Use1D, Use2D, WA3D,
        input  RegWriteD, MemtoRegD, MemAccD, PCSrcD,
        input  CondExE, BranchTakenE,
        output StallF, StallD, StallE, StallM, StallW,
        output FlushD, FlushE, ForwardAE, ForwardBE,
        output PCWrPendingF, MemBusyM
    );
endinterface

// File: rtl/arm_hazard_sb.sv
// Scoreboard hazard unit: tracks E/M/W destination tags itself and derives forwarding,
// load-use stalls, branch/PC-write flushes and a multi-cycle memory stall that freezes the pipe.
module arm_hazard_sb #(
    parameter int REGBITS = 4,
    parameter int PCREG   = 15,
    parameter int MEMLAT  = 0
) (
    input logic           clk,
    input logic           reset,
    arm_hazard_sb_if.slave hz
);
    localparam logic [REGBITS-1:0] PCIDX  = PCREG[REGBITS-1:0];
    localparam logic [2:0]         MEMCNT = MEMLAT[2:0];

    logic [REGBITS-1:0] RA1E, RA2E, WA3E, WA3M, WA3W;
    logic               RegWriteE, MemtoRegE, MemAccE, PCSrcE;
    logic               RegWriteM, PCSrcM;
    logic               RegWriteW, PCSrcW;
    logic [2:0]         cnt;

    logic memStall, ldrStall, pcWrPending, memIssue;
    logic stallF, stallD, stallE, stallM, stallW;
    logic flushD, flushE;
    logic [1:0] fwdA, fwdB;

    always_ff @(posedge clk) begin
        if (reset) begin
            RA1E      <= '0;
            RA2E      <= '0;
            WA3E      <= '0;
            RegWriteE <= 1'b0;
            MemtoRegE <= 1'b0;
            MemAccE   <= 1'b0;
            PCSrcE    <= 1'b0;
            WA3M      <= '0;
            RegWriteM <= 1'b0;
            PCSrcM    <= 1'b0;
            WA3W      <= '0;
            RegWriteW <= 1'b0;
            PCSrcW    <= 1'b0;
            cnt       <= 3'd0;
        end else begin
            if (!stallE) begin
                if (flushE) begin
                    RA1E      <= '0;
                    RA2E      <= '0;
                    WA3E      <= '0;
                    RegWriteE <= 1'b0;
                    MemtoRegE <= 1'b0;
                    MemAccE   <= 1'b0;
                    PCSrcE    <= 1'b0;
                end else begin
                    RA1E      <= hz.RA1D;
                    RA2E      <= hz.RA2D;
                    WA3E      <= hz.WA3D;
                    RegWriteE <= hz.RegWriteD;
                    MemtoRegE <= hz.MemtoRegD;
                    MemAccE   <= hz.MemAccD;
                    PCSrcE    <= hz.PCSrcD;
                end
            end
            // A failed condition turns the E instruction into a no-op from M onward.
            if (!stallM) begin
                WA3M      <= WA3E;
                RegWriteM <= RegWriteE & hz.CondExE;
                PCSrcM    <= PCSrcE & hz.CondExE;
            end
            if (!stallW) begin
                WA3W      <= WA3M;
                RegWriteW <= RegWriteM;
                PCSrcW    <= PCSrcM;
            end
            if (memIssue) begin
                cnt <= MEMCNT;
            end else if (cnt != 3'd0) begin
                cnt <= cnt - 3'd1;
            end
        end
    end

    always_comb begin
        memStall    = (cnt != 3'd0);
        memIssue    = MemAccE && hz.CondExE && !memStall;
        ldrStall    = MemtoRegE && ((hz.Use1D && (hz.RA1D == WA3E)) ||
                                    (hz.Use2D && (hz.RA2D == WA3E)));
        pcWrPending = hz.PCSrcD | PCSrcE | PCSrcM;
        stallF = 1'b0;
        stallD = 1'b0;
        stallE = 1'b0;
        stallM = 1'b0;
        stallW = 1'b0;
        flushD = 1'b0;
        flushE = 1'b0;
        // While memory is busy everything freezes; branch and load-use effects re-evaluate afterwards.
        if (memStall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            stallM = 1'b1;
            stallW = 1'b1;
        end else begin
            stallF = ldrStall | pcWrPending;
            stallD = ldrStall;
            flushD = pcWrPending | PCSrcW | hz.BranchTakenE;
            flushE = ldrStall | hz.BranchTakenE;
        end
    end

    always_comb begin
        fwdA = 2'b00;
        fwdB = 2'b00;
        if (RA1E != PCIDX) begin
            if (RegWriteM && (WA3M == RA1E))      fwdA = 2'b10;
            else if (RegWriteW && (WA3W == RA1E)) fwdA = 2'b01;
        end
        if (RA2E != PCIDX) begin
            if (RegWriteM && (WA3M == RA2E))      fwdB = 2'b10;
            else if (RegWriteW && (WA3W == RA2E)) fwdB = 2'b01;
        end
    end

    assign hz.StallF       = stallF;
    assign hz.StallD       = stallD;
    assign hz.StallE       = stallE;
    assign hz.StallM       = stallM;
    assign hz.StallW       = stallW;
    assign hz.FlushD       = flushD;
    assign hz.FlushE       = flushE;
    assign hz.ForwardAE    = fwdA;
    assign hz.ForwardBE    = fwdB;
    assign hz.PCWrPendingF = pcWrPending;
    assign hz.MemBusyM     = memStall;
endmodule
